mtm_alu_rx: RTL and testbench
=============================

# mtm_alu_rx

Parametrised serial packet receiver for the mtm ALU link. It deserialises the one-bit-per-clock `sin` stream into operand words A and B plus an opcode, and checks frame count, 4-bit CRC and opcode legality. It presents each packet on a ready/valid output register to the ALU core. It is the generalised successor of the fixed 32-bit input stage: operand width is a parameter, and the block adds back-pressure and overflow reporting.

## Interface
- `WORD_BYTES`, default 4: bytes per operand; legal range 1..8. Operand width `W = 8*WORD_BYTES`.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `sin`  in  1  serial data, idle high.
- `out_valid`  out  1  packet held in the output register.
- `out_ready`  in  1  consumer accepts the packet when `out_valid & out_ready`.
- `out_a`  out  W  operand A.
- `out_b`  out  W  operand B.
- `out_op`  out  3  opcode.
- `out_err`  out  3  error flags: {err_data, err_crc, err_op}.
- `overflow`  out  1  one-cycle pulse when a completed packet is dropped.

## Operation
- **Frame format:** 11 bits, one per clock.
  - Start `0`.
  - Type bit: `0` = data, `1` = command.
  - 8 payload bits, MSB first.
  - Stop `1`.
- **Packet:** `2*WORD_BYTES` data frames, then one command frame.
  - Data frames carry B first, MSB byte first, then A, MSB byte first.
  - Command payload is `{1'b0, op[2:0], crc[3:0]}`.
- **Frame receiver FSM:** IDLE → DATA → STOP.
  - IDLE: leaves on `sin==0`.
  - DATA: counts 9 bits (type + payload).
  - STOP: samples the stop bit and always returns to IDLE.
  - Stop bit `1`: `frame_valid` pulses for 1 cycle with type and byte.
  - Stop bit `0`: no frame is emitted; `frame_bad` pulses instead.
- **Packet assembler, data frame:**
  - The byte shifts into a `2*W` shift register.
  - The data counter increments and saturates at `2*WORD_BYTES+1`.
- **`frame_bad`:** sets a sticky `bad` flag; the flag clears when the command frame is processed.
- **Command frame, checks in priority order:**
  - err_data: counter `!= 2*WORD_BYTES`, or `bad` is set. `out_a`/`out_b` are forced to 0.
  - err_crc: received crc differs from CRC-4 (polynomial x^4+x+1, init 0) computed over the bit string {B, A, 1'b1, op}, MSB first.
  - err_op: op is not one of AND=000, OR=001, ADD=100, SUB=101.
  - Only the highest-priority error flag is set; `out_op` is always the received op.
- **Packet completion:**
  - The counter and `bad` clear.
  - The packet loads the output register if it is empty, or if it is being consumed in the same cycle.
  - Otherwise the packet is dropped, `overflow` pulses, and the held packet is unchanged.
- **Reset values:**
  - Outputs: `out_valid=0`, `out_a=0`, `out_b=0`, `out_op=0`, `out_err=0`, `overflow=0`.
  - Internal: frame FSM in IDLE, counter 0, `bad=0`.
- **Reset mid-frame or mid-packet:** everything in progress is discarded; reception resumes at the next `0` seen after reset deasserts.

## Timing
- Stop bit sampled at edge N → `frame_valid` high in cycle N+1.
- `out_valid` rises at edge N+2 for the command frame's stop bit.
- Back-to-back frames are allowed: a start bit may follow the stop bit directly, and the receiver samples it at edge N+1.
- `out_*` stay stable while `out_valid & !out_ready`.
- `out_valid` falls on the edge after the handshake, unless a new packet loads in that same cycle.
- `overflow` is asserted in the same cycle the dropped packet would have loaded.
- Simultaneous `rst` and any other event: reset wins.

## Structure
- **Package `alu_rx_pkg`:**
  - `op_t` enum: AND, OR, ADD, SUB.
  - Frame constants: `FRAME_BITS=11`, `TYPE_DATA=0`, `TYPE_CMD=1`.
  - Error-bit index constants.
  - A `crc4` function parametrised by input width.
- **Sub-module `alu_rx_frame`:** the bit-level frame receiver FSM. Outputs `frame_valid`, `frame_bad`, `frame_type`, `frame_byte`.
- **Top level:** packet assembler, checks, and the output register.

## Test plan
- WORD_BYTES=4, B=0x00000002, A=0x00000003, op=ADD, correct CRC → one `out_valid` with a=0x3, b=0x2, op=100, err=000, rising 2 cycles after the last stop bit.
- Same packet with the CRC LSB flipped → err=010; a and b are still delivered.
- Only 7 data frames, then a command frame → err=100, a=b=0; the next correct packet is received cleanly.
- Op=011 with correct CRC → err=001, op=011.
- `out_ready` held low across two complete packets → first packet held stable, `overflow` pulses once for the second; after `out_ready=1`, only the first packet is observed.
- `rst` for 1 cycle halfway through data frame 5 → no output; an 8-frame packet sent afterwards is received correctly. Also rerun the first scenario with WORD_BYTES=1 and WORD_BYTES=8.

Source files
------------

// File: rtl/alu_rx_pkg.sv
// Shared types, frame constants and the CRC-4 helper for the mtm ALU serial receiver.
// Operand width is carried as a run-time bit count so one CRC routine serves every WORD_BYTES.
package alu_rx_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101
  } op_t;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_DATA = 2'd1,
    FS_STOP = 2'd2
  } frame_state_t;

  localparam int   FRAME_BITS      = 11;
  // Type bit plus 8 payload bits, i.e. everything between start and stop.
  localparam int   FRAME_BODY_BITS = FRAME_BITS - 2;
  localparam logic TYPE_DATA       = 1'b0;
  localparam logic TYPE_CMD        = 1'b1;

  localparam int ERR_DATA = 2;
  localparam int ERR_CRC  = 1;
  localparam int ERR_OP   = 0;

  localparam int MAX_WORD_BYTES = 8;
  localparam int CRC_MAX_BITS   = 16 * MAX_WORD_BYTES + 4;

  function automatic logic op_is_legal(input logic [2:0] op);
    return op inside {OP_AND, OP_OR, OP_ADD, OP_SUB};
  endfunction

  // CRC-4, x^4+x+1, init 0, over the low nbits of data, MSB first.
  function automatic logic [3:0] crc4(input logic [CRC_MAX_BITS-1:0] data, input int nbits);
    logic [3:0] c;
    logic       fb;
    c  = 4'b0000;
    fb = 1'b0;
    for (int i = CRC_MAX_BITS - 1; i >= 0; i--) begin
      if (i < nbits) begin
        fb = c[3] ^ data[i];
        c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/alu_rx_frame.sv
// Bit-level frame receiver: start bit, 9 body bits (type + byte MSB first), stop bit.
// Emits a one-cycle frame_valid on a good stop bit, or frame_bad when the stop bit is 0.
module alu_rx_frame
  import alu_rx_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_sin,
  output logic         o_frame_valid,
  output logic         o_frame_bad,
  output logic         o_frame_type,
  output logic [7:0]   o_frame_byte,
  output frame_state_t o_state
);

  frame_state_t r_state;
  logic [3:0]   r_bit_cnt;
  logic [8:0]   r_body;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= FS_IDLE;
      r_bit_cnt     <= 4'd0;
      r_body        <= 9'd0;
      o_frame_valid <= 1'b0;
      o_frame_bad   <= 1'b0;
      o_frame_type  <= 1'b0;
      o_frame_byte  <= 8'd0;
    end else begin
      o_frame_valid <= 1'b0;
      o_frame_bad   <= 1'b0;
      case (r_state)
        FS_IDLE: begin
          if (!i_sin) begin
            r_state   <= FS_DATA;
            r_bit_cnt <= 4'd0;
          end
        end
        FS_DATA: begin
          r_body <= {r_body[7:0], i_sin};
          if (r_bit_cnt == 4'(FRAME_BODY_BITS - 1)) begin
            r_state <= FS_STOP;
          end else begin
            r_bit_cnt <= r_bit_cnt + 4'd1;
          end
        end
        FS_STOP: begin
          // Always back to IDLE so a start bit right after the stop bit is caught.
          r_state <= FS_IDLE;
          if (i_sin) begin
            o_frame_valid <= 1'b1;
            o_frame_type  <= r_body[8];
            o_frame_byte  <= r_body[7:0];
          end else begin
            o_frame_bad <= 1'b1;
          end
        end
        default: r_state <= FS_IDLE;
      endcase
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/mtm_alu_rx.sv
// mtm ALU link receiver: assembles data frames into operands B and A, checks the command
// frame, and presents each packet on a ready/valid output register with overflow reporting.
module mtm_alu_rx
  import alu_rx_pkg::*;
#(
  parameter int WORD_BYTES = 4  // legal range 1..8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sin,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [8*WORD_BYTES-1:0] out_a,
  output logic [8*WORD_BYTES-1:0] out_b,
  output logic [2:0]              out_op,
  output logic [2:0]              out_err,
  output logic                    overflow,
  output logic [1:0]              dbg_frame_state
);

  localparam int W       = 8 * WORD_BYTES;
  localparam int NFRAMES = 2 * WORD_BYTES;
  localparam int CNT_W   = $clog2(NFRAMES + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NFRAMES);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(NFRAMES + 1);

  logic         w_frame_valid;
  logic         w_frame_bad;
  logic         w_frame_type;
  logic [7:0]   w_frame_byte;
  frame_state_t w_frame_state;

  alu_rx_frame u_frame (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_sin         (sin),
    .o_frame_valid (w_frame_valid),
    .o_frame_bad   (w_frame_bad),
    .o_frame_type  (w_frame_type),
    .o_frame_byte  (w_frame_byte),
    .o_state       (w_frame_state)
  );

  assign dbg_frame_state = w_frame_state;

  logic [2*W-1:0]   r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic             r_bad;

  logic             r_pkt_valid;
  logic [W-1:0]     r_pkt_a;
  logic [W-1:0]     r_pkt_b;
  logic [2:0]       r_pkt_op;
  logic [2:0]       r_pkt_err;

  logic [2:0]              w_cmd_op;
  logic [3:0]              w_cmd_crc;
  logic [3:0]              w_calc_crc;
  logic [CRC_MAX_BITS-1:0] w_crc_in;
  logic                    w_err_data;
  logic                    w_err_crc;
  logic                    w_err_op;
  logic [2:0]              w_err;

  // Command checks; only the highest-priority error survives.
  always_comb begin
    w_cmd_op   = w_frame_byte[6:4];
    w_cmd_crc  = w_frame_byte[3:0];
    w_crc_in   = '0;
    w_crc_in[2*W+3:0] = {r_shift, 1'b1, w_cmd_op};
    w_calc_crc = crc4(w_crc_in, 2 * W + 4);
    w_err_data = (r_cnt != CNT_FULL) || r_bad;
    w_err_crc  = (w_calc_crc != w_cmd_crc);
    w_err_op   = !op_is_legal(w_cmd_op);
    w_err      = 3'b000;
    if (w_err_data) begin
      w_err[ERR_DATA] = 1'b1;
    end else if (w_err_crc) begin
      w_err[ERR_CRC] = 1'b1;
    end else if (w_err_op) begin
      w_err[ERR_OP] = 1'b1;
    end
  end

  // Assembler stage: completed packets land in r_pkt_* one cycle after the command frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift     <= '0;
      r_cnt       <= '0;
      r_bad       <= 1'b0;
      r_pkt_valid <= 1'b0;
      r_pkt_a     <= '0;
      r_pkt_b     <= '0;
      r_pkt_op    <= 3'b000;
      r_pkt_err   <= 3'b000;
    end else begin
      r_pkt_valid <= 1'b0;
      if (w_frame_bad) begin
        r_bad <= 1'b1;
      end
      if (w_frame_valid) begin
        if (w_frame_type == TYPE_DATA) begin
          r_shift <= {r_shift[2*W-9:0], w_frame_byte};
          if (r_cnt != CNT_SAT) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end else if (w_frame_type == TYPE_CMD) begin
          r_cnt       <= '0;
          r_bad       <= 1'b0;
          r_pkt_valid <= 1'b1;
          r_pkt_op    <= w_cmd_op;
          r_pkt_err   <= w_err;
          r_pkt_b     <= w_err_data ? '0 : r_shift[2*W-1:W];
          r_pkt_a     <= w_err_data ? '0 : r_shift[W-1:0];
        end
      end
    end
  end

  // Output register: valid/ready; data is held while out_valid & !out_ready, and a
  // completed packet that finds the register full (and not draining) is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_op    <= 3'b000;
      out_err   <= 3'b000;
      overflow  <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (r_pkt_valid) begin
        if (!out_valid || out_ready) begin
          out_valid <= 1'b1;
          out_a     <= r_pkt_a;
          out_b     <= r_pkt_b;
          out_op    <= r_pkt_op;
          out_err   <= r_pkt_err;
        end else begin
          overflow <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mtm_alu_rx.sv
// Directed bench for mtm_alu_rx: table of packets with hand-written expected outputs for
// WORD_BYTES = 1, 4 and 8, plus hand sequences for back-pressure/overflow and mid-packet reset.
module tb_mtm_alu_rx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        sin1, sin4, sin8;
  logic        ready1, ready4, ready8;
  logic        valid1, valid4, valid8;
  logic [7:0]  a1, b1;
  logic [31:0] a4, b4;
  logic [63:0] a8, b8;
  logic [2:0]  op1, op4, op8, err1, err4, err8;
  logic        ovf1, ovf4, ovf8;
  logic [1:0]  dbg1, dbg4, dbg8;

  mtm_alu_rx #(.WORD_BYTES(1)) u_dut1 (
    .clk(clk), .rst(rst), .sin(sin1), .out_valid(valid1), .out_ready(ready1),
    .out_a(a1), .out_b(b1), .out_op(op1), .out_err(err1), .overflow(ovf1),
    .dbg_frame_state(dbg1)
  );
  mtm_alu_rx #(.WORD_BYTES(4)) u_dut4 (
    .clk(clk), .rst(rst), .sin(sin4), .out_valid(valid4), .out_ready(ready4),
    .out_a(a4), .out_b(b4), .out_op(op4), .out_err(err4), .overflow(ovf4),
    .dbg_frame_state(dbg4)
  );
  mtm_alu_rx #(.WORD_BYTES(8)) u_dut8 (
    .clk(clk), .rst(rst), .sin(sin8), .out_valid(valid8), .out_ready(ready8),
    .out_a(a8), .out_b(b8), .out_op(op8), .out_err(err8), .overflow(ovf8),
    .dbg_frame_state(dbg8)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // Monitors on the WORD_BYTES=4 instance.
  int         ovf_cnt = 0;
  int         hs_cnt  = 0;
  int         stab_err = 0;
  logic       hold_mon = 1'b0;
  logic [31:0] held_a, held_b;
  logic [2:0]  held_op, held_err;

  always @(negedge clk) begin
    if (ovf4) ovf_cnt++;
    if (hold_mon && (!valid4 || a4 !== held_a || b4 !== held_b || op4 !== held_op || err4 !== held_err))
      stab_err++;
  end
  always @(posedge clk) if (valid4 && ready4) hs_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference CRC by polynomial long division of message*x^4 by x^4+x+1.
  function automatic logic [4:0] div_step(input logic [4:0] r, input logic d);
    logic [4:0] n;
    n = {r[3:0], d};
    if (n[4]) n = n ^ 5'b10011;
    return n;
  endfunction

  function automatic logic [3:0] ref_crc(input int wb, input logic [63:0] b, input logic [63:0] a,
                                         input logic [2:0] op);
    logic [4:0] r;
    r = 5'd0;
    for (int i = 8 * wb - 1; i >= 0; i--) r = div_step(r, b[i]);
    for (int i = 8 * wb - 1; i >= 0; i--) r = div_step(r, a[i]);
    r = div_step(r, 1'b1);
    for (int i = 2; i >= 0; i--) r = div_step(r, op[i]);
    for (int i = 0; i < 4; i++) r = div_step(r, 1'b0);
    return r[3:0];
  endfunction

  task automatic drive_bit(input int wb, input logic bv);
    @(negedge clk);
    case (wb)
      1:       sin1 = bv;
      8:       sin8 = bv;
      default: sin4 = bv;
    endcase
  endtask

  task automatic send_frame(input int wb, input logic typ, input logic [7:0] byt, input logic stop);
    drive_bit(wb, 1'b0);
    drive_bit(wb, typ);
    for (int k = 7; k >= 0; k--) drive_bit(wb, byt[k]);
    drive_bit(wb, stop);
  endtask

  task automatic send_packet(input int wb, input logic [63:0] b, input logic [63:0] a,
                             input logic [2:0] op, input logic crc_flip, input int nfr,
                             input int bad_idx);
    logic [3:0] crc;
    logic [7:0] byt;
    crc = ref_crc(wb, b, a, op) ^ {3'b000, crc_flip};
    for (int i = 0; i < nfr; i++) begin
      if (i < wb) byt = b[8*(wb-1-i) +: 8];
      else if (i < 2 * wb) byt = a[8*(2*wb-1-i) +: 8];
      else byt = 8'h00;
      send_frame(wb, 1'b0, byt, (i == bad_idx) ? 1'b0 : 1'b1);
    end
    send_frame(wb, 1'b1, {1'b0, op, crc}, 1'b1);
  endtask

  task automatic sample(input int wb, output logic v, output logic [63:0] a, output logic [63:0] b,
                        output logic [2:0] op, output logic [2:0] err);
    case (wb)
      1:       begin v = valid1; a = 64'(a1); b = 64'(b1); op = op1; err = err1; end
      8:       begin v = valid8; a = a8;      b = b8;      op = op8; err = err8; end
      default: begin v = valid4; a = 64'(a4); b = 64'(b4); op = op4; err = err4; end
    endcase
  endtask

  // Called right after the command stop bit is driven; out_valid is due 3 edges later.
  task automatic check_pkt(input string tag, input int wb, input logic [63:0] ea,
                           input logic [63:0] eb, input logic [2:0] eop, input logic [2:0] eerr);
    logic        v;
    logic [63:0] a, b;
    logic [2:0]  op, err;
    int          lat;
    lat = 0;
    v   = 1'b0;
    while (!v && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      sample(wb, v, a, b, op, err);
    end
    check({tag, ".latency"}, 64'(lat), 64'd3);
    check({tag, ".valid"}, 64'(v), 64'd1);
    check({tag, ".a"}, a, ea);
    check({tag, ".b"}, b, eb);
    check({tag, ".op"}, 64'(op), 64'(eop));
    check({tag, ".err"}, 64'(err), 64'(eerr));
  endtask

  typedef struct {
    int          wb;
    logic [63:0] b;
    logic [63:0] a;
    logic [2:0]  op;
    logic        crc_flip;
    int          nfr;
    int          bad_idx;
    logic [63:0] exp_a;
    logic [63:0] exp_b;
    logic [2:0]  exp_op;
    logic [2:0]  exp_err;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  initial begin
    int ovf0, hs0;

    vecs[0]  = '{4, 64'h2, 64'h3, 3'b100, 1'b0, 8, -1, 64'h3, 64'h2, 3'b100, 3'b000};
    vecs[1]  = '{4, 64'h2, 64'h3, 3'b100, 1'b1, 8, -1, 64'h3, 64'h2, 3'b100, 3'b010};
    vecs[2]  = '{4, 64'h2, 64'h3, 3'b100, 1'b0, 7, -1, 64'h0, 64'h0, 3'b100, 3'b100};
    vecs[3]  = '{4, 64'hDEADBEEF, 64'h12345678, 3'b000, 1'b0, 8, -1,
                 64'h12345678, 64'hDEADBEEF, 3'b000, 3'b000};
    vecs[4]  = '{4, 64'hA5A50F0F, 64'h000000FF, 3'b011, 1'b0, 8, -1,
                 64'h000000FF, 64'hA5A50F0F, 3'b011, 3'b001};
    vecs[5]  = '{4, 64'h1, 64'h1, 3'b110, 1'b1, 8, -1, 64'h1, 64'h1, 3'b110, 3'b010};
    vecs[6]  = '{4, 64'h01020304, 64'h05060708, 3'b001, 1'b0, 9, 2, 64'h0, 64'h0, 3'b001, 3'b100};
    vecs[7]  = '{4, 64'hCAFEF00D, 64'h80000001, 3'b101, 1'b0, 8, -1,
                 64'h80000001, 64'hCAFEF00D, 3'b101, 3'b000};
    vecs[8]  = '{4, 64'h2, 64'h3, 3'b100, 1'b0, 9, -1, 64'h0, 64'h0, 3'b100, 3'b100};
    vecs[9]  = '{1, 64'h2, 64'h3, 3'b100, 1'b0, 2, -1, 64'h3, 64'h2, 3'b100, 3'b000};
    vecs[10] = '{8, 64'h2, 64'h3, 3'b100, 1'b0, 16, -1, 64'h3, 64'h2, 3'b100, 3'b000};
    vecs[11] = '{8, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 3'b101, 1'b0, 16, -1,
                 64'hFEDCBA9876543210, 64'h0123456789ABCDEF, 3'b101, 3'b000};

    // Clock/reset
    rst = 1'b1;
    sin1 = 1'b1; sin4 = 1'b1; sin8 = 1'b1;
    ready1 = 1'b1; ready4 = 1'b1; ready8 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset.valid4", 64'(valid4), 64'd0);
    check("reset.a4", 64'(a4), 64'd0);
    check("reset.b4", 64'(b4), 64'd0);
    check("reset.op4", 64'(op4), 64'd0);
    check("reset.err4", 64'(err4), 64'd0);
    check("reset.ovf4", 64'(ovf4), 64'd0);
    check("reset.state4", 64'(dbg4), 64'd0);
    check("reset.valid1", 64'(valid1), 64'd0);
    check("reset.valid8", 64'(valid8), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Table of packets
    ovf0 = ovf_cnt;
    for (int i = 0; i < NV; i++) begin
      send_packet(vecs[i].wb, vecs[i].b, vecs[i].a, vecs[i].op, vecs[i].crc_flip,
                  vecs[i].nfr, vecs[i].bad_idx);
      check_pkt($sformatf("vec%0d", i), vecs[i].wb, vecs[i].exp_a, vecs[i].exp_b,
                vecs[i].exp_op, vecs[i].exp_err);
    end
    repeat (3) @(posedge clk);
    #1;
    check("table.no_overflow", 64'(ovf_cnt - ovf0), 64'd0);
    check("table.drained", 64'(valid4), 64'd0);

    // Back-pressure: second packet dropped while the first is held
    @(negedge clk);
    ready4 = 1'b0;
    ovf0 = ovf_cnt;
    hs0  = hs_cnt;
    send_packet(4, 64'h11223344, 64'h55667788, 3'b101, 1'b0, 8, -1);
    check_pkt("hold.p1", 4, 64'h55667788, 64'h11223344, 3'b101, 3'b000);
    held_a = 32'h55667788; held_b = 32'h11223344; held_op = 3'b101; held_err = 3'b000;
    hold_mon = 1'b1;
    send_packet(4, 64'h99, 64'hAA, 3'b100, 1'b0, 8, -1);
    repeat (5) @(posedge clk);
    #1;
    check("hold.overflow_pulses", 64'(ovf_cnt - ovf0), 64'd1);
    check("hold.stable", 64'(stab_err), 64'd0);
    check("hold.a", 64'(a4), 64'h55667788);
    check("hold.valid", 64'(valid4), 64'd1);
    @(negedge clk);
    hold_mon = 1'b0;
    ready4 = 1'b1;
    @(posedge clk);
    #1;
    check("hold.valid_after_hs", 64'(valid4), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    check("hold.handshakes", 64'(hs_cnt - hs0), 64'd1);

    // Reset halfway through data frame 5
    hs0 = hs_cnt;
    for (int i = 0; i < 4; i++) send_frame(4, 1'b0, 8'h5A + 8'(i), 1'b1);
    drive_bit(4, 1'b0);
    drive_bit(4, 1'b0);
    drive_bit(4, 1'b1);
    drive_bit(4, 1'b0);
    drive_bit(4, 1'b1);
    @(negedge clk);
    rst  = 1'b1;
    sin4 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("midrst.valid", 64'(valid4), 64'd0);
    check("midrst.state", 64'(dbg4), 64'd0);
    check("midrst.handshakes", 64'(hs_cnt - hs0), 64'd0);
    send_packet(4, 64'h0BADF00D, 64'h00C0FFEE, 3'b001, 1'b0, 8, -1);
    check_pkt("midrst.next", 4, 64'h00C0FFEE, 64'h0BADF00D, 3'b001, 3'b000);

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
